// File: rtl/tri_host_if.sv
// Host-side driver for the triangle engine: queues descriptors, sends the three
// vertices, then collects the returned pixel stream into an 8x8 bitmap.
module tri_host_if #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [17:0] cmd_data,
  output logic        cmd_ready,
  output logic        nt,
  output logic [2:0]  xi,
  output logic [2:0]  yi,
  input  logic        busy,
  input  logic        po,
  input  logic [2:0]  xo,
  input  logic [2:0]  yo,
  output logic [63:0] bitmap,
  output logic [6:0]  pix_cnt,
  output logic        tri_done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND1, S_SEND2, S_SEND3, S_WAIT_BUSY, S_COLLECT, S_DONE
  } state_t;

  state_t        r_state;
  logic [17:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic          r_cmd_ready;
  logic [11:0]   r_desc;
  logic          r_nt;
  logic [2:0]    r_xi, r_yi;
  logic [63:0]   r_bitmap;
  logic [6:0]    r_pix_cnt;
  logic          r_tri_done;
  logic          r_err;
  logic [1:0]    r_err_code;
  logic [CW-1:0] r_cnt;

  logic          w_empty, w_push, w_pop, w_full_nxt;
  logic [PW-1:0] w_wptr_nxt, w_rptr_nxt;
  logic [17:0]   w_head;
  logic [5:0]    w_pix_idx;
  logic          w_dup;
  logic [CW-1:0] w_cnt_inc;
  logic          w_timeout;
  logic          w_err_req;
  logic [1:0]    w_err_code;

  // FIFO bookkeeping; the extra pointer MSB separates full from empty
  always_comb begin
    w_empty    = (r_wptr == r_rptr);
    w_push     = cmd_valid && r_cmd_ready;
    w_pop      = (r_state == S_IDLE) && !w_empty && !busy;
    w_wptr_nxt = w_push ? r_wptr + PW'(1) : r_wptr;
    w_rptr_nxt = w_pop  ? r_rptr + PW'(1) : r_rptr;
    w_full_nxt = (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                 (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
    w_head     = r_mem[r_rptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= cmd_data;
  end

  // Error sources; a timeout and a stray pixel can coincide, timeout reported then
  always_comb begin
    w_pix_idx  = {yo, xo};
    w_dup      = r_bitmap[w_pix_idx];
    w_cnt_inc  = r_cnt + CW'(1);
    w_timeout  = (r_state == S_WAIT_BUSY) && !busy && (w_cnt_inc == CW'(TIMEOUT));
    w_err_req  = 1'b0;
    w_err_code = 2'b00;
    if (po && (r_state != S_COLLECT)) begin
      w_err_req  = 1'b1;
      w_err_code = 2'b11;
    end else if (po && w_dup) begin
      w_err_req  = 1'b1;
      w_err_code = 2'b10;
    end
    if (w_timeout) begin
      w_err_req  = 1'b1;
      w_err_code = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cmd_ready <= 1'b1;
      r_desc      <= '0;
      r_nt        <= 1'b0;
      r_xi        <= '0;
      r_yi        <= '0;
      r_bitmap    <= '0;
      r_pix_cnt   <= '0;
      r_tri_done  <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
      r_cnt       <= '0;
    end else begin
      r_wptr      <= w_wptr_nxt;
      r_rptr      <= w_rptr_nxt;
      r_cmd_ready <= !w_full_nxt;
      if (w_err_req && !r_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code;
      end
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_desc    <= w_head[11:0];
            r_nt      <= 1'b1;
            r_xi      <= w_head[17:15];
            r_yi      <= w_head[14:12];
            r_bitmap  <= '0;
            r_pix_cnt <= '0;
            r_cnt     <= '0;
            r_state   <= S_SEND1;
          end
        end
        S_SEND1: begin
          r_nt    <= 1'b0;
          r_xi    <= r_desc[11:9];
          r_yi    <= r_desc[8:6];
          r_state <= S_SEND2;
        end
        S_SEND2: begin
          r_xi    <= r_desc[5:3];
          r_yi    <= r_desc[2:0];
          r_state <= S_SEND3;
        end
        S_SEND3: begin
          r_xi    <= '0;
          r_yi    <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (busy) begin
            r_state <= S_COLLECT;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_timeout) begin
              r_tri_done <= 1'b1;
              r_state    <= S_DONE;
            end
          end
        end
        S_COLLECT: begin
          // a pixel in the same cycle busy drops still belongs to this triangle
          if (po && !w_dup) begin
            r_bitmap[w_pix_idx] <= 1'b1;
            r_pix_cnt <= (r_pix_cnt == 7'd64) ? r_pix_cnt : r_pix_cnt + 7'd1;
          end
          if (!busy) begin
            r_tri_done <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_tri_done <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign nt        = r_nt;
  assign xi        = r_xi;
  assign yi        = r_yi;
  assign bitmap    = r_bitmap;
  assign pix_cnt   = r_pix_cnt;
  assign tri_done  = r_tri_done;
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_tri_host_if.sv
// Directed bench for tri_host_if: vertex serialisation, FIFO limits, timeout,
// duplicate/stray pixel errors and mid-triangle reset.
module tb_tri_host_if;

  localparam int unsigned TIMEOUT = 15;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic [17:0] cmd_data;
  logic        cmd_ready;
  logic        nt;
  logic [2:0]  xi, yi;
  logic        busy, po;
  logic [2:0]  xo, yo;
  logic [63:0] bitmap;
  logic [6:0]  pix_cnt;
  logic        tri_done, err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_errs   = 0;

  logic [2:0]  px [8];
  logic [2:0]  py [8];
  logic [17:0] dq [4];

  tri_host_if #(.DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .nt(nt), .xi(xi), .yi(yi), .busy(busy), .po(po),
    .xo(xo), .yo(yo), .bitmap(bitmap), .pix_cnt(pix_cnt), .tri_done(tri_done),
    .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] pack(input logic [2:0] x1, y1, x2, y2, x3, y3);
    return {x1, y1, x2, y2, x3, y3};
  endfunction

  task automatic do_reset();
    rst = 1'b0; cmd_valid = 1'b0; busy = 1'b0; po = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic push(input logic [17:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
  endtask

  // wait for the nt strobe, then check the three vertices and the idle bus after
  task automatic issue_check(input logic [17:0] d);
    for (int i = 0; i < 20 && nt !== 1'b1; i++) step();
    check("nt_rise", 64'(nt), 64'(1));
    check("vtx1", 64'({xi, yi}), 64'(d[17:12]));
    step();
    check("vtx2", 64'({nt, xi, yi}), 64'({1'b0, d[11:6]}));
    step();
    check("vtx3", 64'({nt, xi, yi}), 64'({1'b0, d[5:0]}));
    step();
    check("vtx_idle", 64'({nt, xi, yi}), 64'(0));
  endtask

  // engine model: busy one cycle after WAIT_BUSY entry, n pixels, busy drops
  task automatic do_engine(input int n, input logic [6:0] exp_cnt, input logic [63:0] exp_bm);
    busy = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      po = 1'b1; xo = px[i]; yo = py[i];
      step();
    end
    po = 1'b0; busy = 1'b0;
    step();
    check("tri_done", 64'(tri_done), 64'(1));
    check("pix_cnt", 64'(pix_cnt), 64'(exp_cnt));
    check("bitmap", bitmap, exp_bm);
    step();
    check("tri_done_pulse", 64'(tri_done), 64'(0));
  endtask

  initial begin
    int seen;
    logic [17:0] d;
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; busy = 1'b0; po = 1'b0; xo = '0; yo = '0;
    #1 rst = 1'b0;
    step(); step();
    check("rst_nt", 64'({nt, xi, yi}), 64'(0));
    check("rst_done", 64'({tri_done, err, err_code}), 64'(0));
    check("rst_bitmap", bitmap, 64'(0));
    check("rst_pix_cnt", 64'(pix_cnt), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    rst = 1'b1;
    step();

    // 1: single triangle, six pixels
    d = pack(3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3);
    push(d);
    issue_check(d);
    px[0] = 1; py[0] = 1;  px[1] = 1; py[1] = 2;  px[2] = 1; py[2] = 3;
    px[3] = 2; py[3] = 2;  px[4] = 2; py[4] = 3;  px[5] = 3; py[5] = 3;
    do_engine(6, 7'd6, 64'h0000_0000_0E06_0200);
    check("t1_err", 64'(err), 64'(0));

    // 2: fill the FIFO while the engine is busy
    dq[0] = pack(3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5);
    dq[1] = pack(3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0);
    dq[2] = pack(3'd7, 3'd7, 3'd0, 3'd0, 3'd7, 3'd0);
    dq[3] = pack(3'd2, 3'd4, 3'd6, 3'd1, 3'd3, 3'd5);
    busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t2_ready_before", 64'(cmd_ready), 64'(1));
      push(dq[k]);
    end
    check("t2_full", 64'(cmd_ready), 64'(0));
    push(pack(3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6));
    check("t2_still_full", 64'(cmd_ready), 64'(0));
    check("t2_no_issue", 64'(nt), 64'(0));
    busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      issue_check(dq[k]);
      px[0] = 3'(k); py[0] = 3'(k);
      do_engine(1, 7'd1, 64'(1) << (9 * k));
    end
    seen = 0;
    repeat (10) begin
      step();
      if (nt) seen++;
    end
    check("t2_no_5th", 64'(seen), 64'(0));
    check("t2_err", 64'(err), 64'(0));

    // 3: engine never answers
    d = pack(3'd2, 3'd0, 3'd0, 3'd2, 3'd4, 3'd4);
    push(d);
    issue_check(d);
    repeat (TIMEOUT - 1) step();
    check("t3_err_early", 64'(err), 64'(0));
    step();
    check("t3_err", 64'({err, err_code}), 64'({1'b1, 2'b01}));
    check("t3_done", 64'(tri_done), 64'(1));
    step();
    check("t3_done_pulse", 64'(tri_done), 64'(0));
    d = pack(3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6);
    push(d);
    issue_check(d);
    do_engine(0, 7'd0, 64'(0));

    // 4: duplicate pixel (2,2)
    do_reset();
    d = pack(3'd2, 3'd2, 3'd3, 3'd2, 3'd2, 3'd3);
    push(d);
    issue_check(d);
    px[0] = 2; py[0] = 2;  px[1] = 2; py[1] = 2;  px[2] = 3; py[2] = 2;
    do_engine(3, 7'd2, 64'h0000_0000_000C_0000);
    check("t4_err", 64'({err, err_code}), 64'({1'b1, 2'b10}));
    check("t4_bit18", 64'(bitmap[18]), 64'(1));

    // 5: stray pixel in IDLE, then a duplicate must not overwrite the code
    do_reset();
    po = 1'b1; xo = 3'd5; yo = 3'd5;
    step();
    po = 1'b0;
    check("t5_err", 64'({err, err_code}), 64'({1'b1, 2'b11}));
    check("t5_ignored", bitmap, 64'(0));
    d = pack(3'd1, 3'd1, 3'd2, 3'd1, 3'd1, 3'd2);
    push(d);
    issue_check(d);
    px[0] = 1; py[0] = 1;  px[1] = 1; py[1] = 1;
    do_engine(2, 7'd1, 64'h0000_0000_0000_0200);
    check("t5_sticky", 64'(err_code), 64'(3));

    // 6: reset in COLLECT with two descriptors pending
    do_reset();
    busy = 1'b1;
    push(pack(3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd7));
    push(pack(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6));
    push(pack(3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1));
    busy = 1'b0;
    issue_check(pack(3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd7));
    busy = 1'b1;
    step();
    po = 1'b1; xo = 3'd4; yo = 3'd4;
    step();
    po = 1'b0;
    check("t6_collect_cnt", 64'(pix_cnt), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("t6_nt", 64'(nt), 64'(0));
    check("t6_bitmap", bitmap, 64'(0));
    check("t6_pix_cnt", 64'(pix_cnt), 64'(0));
    check("t6_ready", 64'(cmd_ready), 64'(1));
    busy = 1'b0;
    step(); step();
    rst = 1'b1;
    seen = 0;
    repeat (10) begin
      step();
      if (nt) seen++;
    end
    check("t6_no_nt", 64'(seen), 64'(0));
    d = pack(3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2);
    push(d);
    issue_check(d);
    px[0] = 7; py[0] = 7;
    do_engine(1, 7'd1, 64'h8000_0000_0000_0000);
    check("t6_err", 64'(err), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/tri_host_if.md
Name: tri_host_if

Overview:
- Host-side counterpart of the triangle rendering engine.
- Accepts triangle descriptors from a small command FIFO and serialises each one onto the engine input protocol (nt pulse, then three vertices on xi/yi).
- Then acts as the receiver of the engine's pixel stream (po/xo/yo).
- Accumulates each triangle's pixels into an 8x8 bitmap with a pixel count, and flags protocol errors.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
TIMEOUT, 15, max cycles from last vertex to engine busy rising before error

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  descriptor offered
cmd_data  input  18  {x1,y1,x2,y2,x3,y3}, 3 bits each, x1 in [17:15]
cmd_ready  output  1  FIFO not full
nt  output  1  new-triangle strobe to engine
xi  output  3  vertex x to engine
yi  output  3  vertex y to engine
busy  input  1  engine busy
po  input  1  engine pixel-valid
xo  input  3  pixel x
yo  input  3  pixel y
bitmap  output  64  pixels of last triangle, bit index yo*8+xo
pix_cnt  output  7  pixels counted for current/last triangle (0..64)
tri_done  output  1  one-cycle pulse, triangle complete, bitmap/pix_cnt valid
err  output  1  sticky error flag
err_code  output  2  01 busy timeout, 10 duplicate pixel, 11 po while not collecting

Behaviour:
- Reset (rst=0, async) values:
  - nt=0, xi=yi=0, tri_done=0, err=0, err_code=0, bitmap=0, pix_cnt=0.
  - FIFO empty, cmd_ready=1, FSM=IDLE.
  - Mid-operation reset aborts the triangle; the FIFO contents are discarded.
- FIFO:
  - Write when cmd_valid&cmd_ready. cmd_ready=0 when DEPTH entries held.
  - Pop only on the IDLE->SEND1 transition.
  - Simultaneous push and pop when full is not permitted, because cmd_ready is already 0.
  - Wrap-around pointers with an extra MSB for full/empty.
- FSM states: IDLE, SEND1, SEND2, SEND3, WAIT_BUSY, COLLECT, DONE.
- IDLE: when FIFO non-empty and busy=0, pop the head into the descriptor register and go to SEND1.
- SEND1: nt=1, xi/yi=x1/y1 for exactly one cycle.
  - On entry, clear bitmap and pix_cnt and the timeout counter.
- SEND2: nt=0, xi/yi=x2/y2, one cycle.
- SEND3: nt=0, xi/yi=x3/y3, one cycle.
- Outside SEND1..3, xi/yi=0 and nt=0.
- WAIT_BUSY: the counter increments each cycle.
  - busy=1 -> COLLECT.
  - Counter reaching TIMEOUT with busy=0 -> set err, err_code=01, go to DONE.
- COLLECT: each cycle po=1 does the following:
  - If bitmap[yo*8+xo] is already set, set err with err_code=10. The bit stays set and pix_cnt does not increment.
  - Otherwise set the bit and increment pix_cnt.
  - busy falling to 0 -> DONE. A po sampled in the same cycle busy=0 is still accepted.
- DONE: tri_done=1 for one cycle, then IDLE.
  - bitmap and pix_cnt hold until the next SEND1.
- Back-to-back triangles: the earliest SEND1 is 2 cycles after busy falls (DONE, IDLE).
- po=1 in IDLE/SEND*/WAIT_BUSY/DONE: the pixel is ignored, err is set, err_code=11.
- err/err_code are sticky until reset. The first error code wins; later errors do not overwrite it.
- Errors never stall the FSM.
- pix_cnt saturates at 64.

Test Plan:
1. Reset, push one descriptor {1,1,1,3,3,3}:
   - Required: SEND1 shows nt=1, xi=1, yi=1 for one cycle; then (1,3); then (3,3).
   - Model engine raises busy 1 cycle later, emits 6 pixels, drops busy.
   - Required: tri_done pulse, pix_cnt=6, bitmap has exactly those 6 bits, err=0.
2. Push DEPTH=4 descriptors while the engine is held busy:
   - Required: cmd_ready=0 after the 4th.
   - Required: 5th cmd_valid ignored.
   - Required: all 4 triangles issued in order, 4 tri_done pulses.
3. Engine never raises busy after SEND3:
   - Required: err=1, err_code=01 exactly TIMEOUT cycles after WAIT_BUSY entry, tri_done pulses, FSM returns to IDLE.
4. Engine emits pixel (2,2) twice:
   - Required: pix_cnt counts it once, err=1, err_code=10, bit 18 set.
5. po=1 while in IDLE:
   - Required: err_code=11.
   - Then a later duplicate pixel leaves err_code=11.
6. Assert rst=0 during COLLECT with 2 FIFO entries pending:
   - Required: immediate nt=0, bitmap=0, pix_cnt=0, cmd_ready=1, no further nt after release until a new push.
